// File: rtl/cpu_clk_ctrl.sv
// Step-enable controller for the lab CPU: halt, free-run, single-step and burst.
// Owns the step-rate divider and the push-button debouncer.
module cpu_clk_ctrl #(
  parameter int          CNT_W     = 32,
  parameter int unsigned DEF_DIV   = 25000000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic             clkin,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  input  logic [7:0]       burst_len,
  output logic             cpu_en,
  output logic             clkout,
  output logic             busy,
  output logic [15:0]      tick_cnt
);

  typedef enum logic [1:0] {
    M_HALT  = 2'b00,
    M_RUN   = 2'b01,
    M_STEP  = 2'b10,
    M_BURST = 2'b11
  } mode_t;

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic             s1_reg, s2_reg;
  logic             db_level_reg, db_level_next;
  logic             db_prev_reg;
  logic [DB_W-1:0]  db_cnt_reg, db_cnt_next;
  logic             press_reg, press_next;

  mode_t            mode_q_reg;
  logic [CNT_W-1:0] divisor_reg, divisor_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [8:0]       remain_reg, remain_next;
  logic             busy_next;
  logic             en_next;

  logic             mode_chg;
  logic             run_en;
  logic             tick;

  // Debouncer: the level only follows s2 after it has differed for DB_CYCLES samples.
  always_comb begin
    db_level_next = db_level_reg;
    db_cnt_next   = '0;
    if (s2_reg != db_level_reg) begin
      if (db_cnt_reg == DB_LAST) db_level_next = s2_reg;
      else                       db_cnt_next   = db_cnt_reg + DB_W'(1);
    end
    press_next = db_level_reg & ~db_prev_reg;
  end

  always_comb begin
    mode_chg = (mode != mode_q_reg);
    run_en   = (mode == M_RUN) || ((mode == M_BURST) && busy);
    tick     = run_en && !mode_chg && (count_reg >= divisor_reg - CNT_W'(1));
    en_next  = tick || ((mode == M_STEP) && press_reg && !mode_chg);

    count_next = (!run_en || mode_chg || tick) ? '0 : count_reg + CNT_W'(1);

    divisor_next = divisor_reg;
    if (div_load) divisor_next = (div_val == '0) ? CNT_W'(1) : div_val;

    busy_next   = busy;
    remain_next = remain_reg;
    if (mode_chg || (mode != M_BURST)) begin
      busy_next   = 1'b0;
      remain_next = '0;
    end else if (busy) begin
      if (tick) begin
        remain_next = remain_reg - 9'd1;
        if (remain_reg == 9'd1) busy_next = 1'b0;
      end
    end else if (press_reg) begin
      remain_next = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
      busy_next   = 1'b1;
    end
  end

  // mode_q resets to HALT so a non-HALT mode held through reset counts as a change.
  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      db_level_reg <= 1'b0;
      db_prev_reg  <= 1'b0;
      db_cnt_reg   <= '0;
      press_reg    <= 1'b0;
      mode_q_reg   <= M_HALT;
      divisor_reg  <= CNT_W'(DEF_DIV);
      count_reg    <= '0;
      remain_reg   <= '0;
      busy         <= 1'b0;
      cpu_en       <= 1'b0;
      clkout       <= 1'b0;
      tick_cnt     <= '0;
    end else begin
      s1_reg       <= step_btn;
      s2_reg       <= s1_reg;
      db_level_reg <= db_level_next;
      db_prev_reg  <= db_level_reg;
      db_cnt_reg   <= db_cnt_next;
      press_reg    <= press_next;
      mode_q_reg   <= mode_t'(mode);
      divisor_reg  <= divisor_next;
      count_reg    <= count_next;
      remain_reg   <= remain_next;
      busy         <= busy_next;
      cpu_en       <= en_next;
      clkout       <= clkout ^ en_next;
      if (en_next) tick_cnt <= tick_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomized bench for cpu_clk_ctrl: expected step times are derived from the
// timing rules (entry edge + k*divisor, button latency DB+4) and compared to the DUT.
module tb_cpu_clk_ctrl;

  localparam int DB = 4;

  logic        clkin = 1'b0;
  logic        clr;
  logic [1:0]  mode;
  logic        step_btn;
  logic        div_load;
  logic [15:0] div_val;
  logic [7:0]  burst_len;
  logic        cpu_en, clkout, busy;
  logic [15:0] tick_cnt;

  cpu_clk_ctrl #(.CNT_W(16), .DEF_DIV(4), .DB_CYCLES(DB)) dut (
    .clkin(clkin), .clr(clr), .mode(mode), .step_btn(step_btn),
    .div_load(div_load), .div_val(div_val), .burst_len(burst_len),
    .cpu_en(cpu_en), .clkout(clkout), .busy(busy), .tick_cnt(tick_cnt)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  // Each entry is the number of the edge after which cpu_en was high.
  int pulses[$];
  int exp_q[$];
  always @(negedge clkin) if (cpu_en) pulses.push_back(cyc);

  int errors = 0, checks = 0;
  int exp_ticks = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic load_div(input int v);
    div_load = 1'b1;
    div_val  = 16'(v);
    adv(1);
    div_load = 1'b0;
  endtask

  task automatic check_pulses(input string tag);
    chk({tag, "_count"}, pulses.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulses.size(); i++)
      chk({tag, "_edge"}, pulses[i], exp_q[i]);
    exp_ticks += exp_q.size();
    chk({tag, "_tick_cnt"}, tick_cnt, exp_ticks & 'hFFFF);
    chk({tag, "_clkout"}, clkout, exp_ticks & 1);
    $display("%s: %0d pulses expected, %0d seen, tick_cnt=%0d", tag, exp_q.size(), pulses.size(), tick_cnt);
    pulses.delete();
    exp_q.delete();
  endtask

  // Clean press: rise now, hold h cycles, release; returns the rise edge number.
  task automatic press(input int h, output int e);
    e = cyc;
    step_btn = 1'b1;
    adv(h);
    step_btn = 1'b0;
  endtask

  initial begin
    int e, d, n, v, c, h, m, last;
    clr = 1'b1; mode = 2'b00; step_btn = 1'b0; div_load = 1'b0;
    div_val = '0; burst_len = '0;
    #2;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_clkout", clkout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick_cnt", tick_cnt, 0);
    adv(2);
    clr = 1'b0;
    adv(2);

    // RUN at the reset divisor of 4, ten steps
    e = cyc; mode = 2'b01;
    for (int k = 1; k <= 10; k++) exp_q.push_back(e + 1 + 4 * k);
    adv(41);
    mode = 2'b00;
    adv(2);
    check_pulses("run_def");

    for (int t = 0; t < 3; t++) begin
      d = $urandom_range(1, 9); n = $urandom_range(2, 6);
      load_div(d);
      e = cyc; mode = 2'b01;
      for (int k = 1; k <= n; k++) exp_q.push_back(e + 1 + d * k);
      adv(1 + d * n);
      mode = 2'b00;
      adv(2);
      check_pulses("run_rand");
    end

    // STEP: glitches shorter than the debounce window, then clean presses
    mode = 2'b10;
    adv(2);
    for (int t = 0; t < 2; t++) begin
      press($urandom_range(1, DB - 1), e);
      adv(10);
      check_pulses("step_glitch");
    end
    for (int t = 0; t < 3; t++) begin
      h = $urandom_range(6, 20);
      press(h, e);
      exp_q.push_back(e + DB + 4);
      adv(12);
      check_pulses("step_press");
    end

    // BURST of 3 at divisor 2
    mode = 2'b11; burst_len = 8'd3;
    load_div(2);
    adv(2);
    press(6, e);
    for (int k = 1; k <= 3; k++) exp_q.push_back(e + DB + 4 + 2 * k);
    adv(4);
    chk("burst3_busy_mid", busy, 1);
    adv(4);
    chk("burst3_busy_end", busy, 0);
    adv(2);
    check_pulses("burst3");

    // longer burst with a second press that must be ignored
    d = $urandom_range(4, 6); n = $urandom_range(8, 12);
    burst_len = 8'(n);
    load_div(d);
    adv(2);
    press(6, e);
    adv(8);
    step_btn = 1'b1;
    adv(6);
    step_btn = 1'b0;
    chk("burst_busy_mid", busy, 1);
    last = e + DB + 4 + d * n;
    for (int k = 1; k <= n; k++) exp_q.push_back(e + DB + 4 + d * k);
    adv(last - cyc);
    chk("burst_busy_end", busy, 0);
    adv(20);
    check_pulses("burst_repress");

    // 256-step burst at divisor 1
    burst_len = 8'd0;
    load_div(0);
    adv(2);
    press(6, e);
    for (int k = 1; k <= 256; k++) exp_q.push_back(e + DB + 4 + k);
    adv(DB + 4 + 256 - 6);
    chk("burst256_busy_end", busy, 0);
    adv(4);
    check_pulses("burst256");

    // HALT in the middle of a burst
    load_div(2);
    adv(2);
    press(6, e);
    m = $urandom_range(3, 20);
    h = e + DB + 4 + 2 * m + 1;
    for (int k = 1; e + DB + 4 + 2 * k <= h; k++) exp_q.push_back(e + DB + 4 + 2 * k);
    adv(h - cyc);
    mode = 2'b00;
    adv(1);
    chk("halt_abort_busy", busy, 0);
    adv(10);
    check_pulses("burst_halt");

    // divisor reload below the current count
    load_div(10);
    c = $urandom_range(3, 7); v = $urandom_range(1, c);
    e = cyc; mode = 2'b01;
    adv(1 + c);
    load_div(v);
    for (int k = 0; k < 4; k++) exp_q.push_back(e + 3 + c + v * k);
    adv(1 + 3 * v);
    mode = 2'b00;
    adv(2);
    check_pulses("reload_low");

    // reload in the same cycle as a tick: that tick keeps the old divisor
    load_div(10);
    v = $urandom_range(12, 20);
    e = cyc; mode = 2'b01;
    adv(10);
    load_div(v);
    exp_q.push_back(e + 11);
    exp_q.push_back(e + 11 + v);
    exp_q.push_back(e + 11 + 2 * v);
    adv(2 * v);
    mode = 2'b00;
    adv(2);
    check_pulses("reload_same_tick");

    // divisor 0 stored as 1: continuous enable
    load_div(0);
    e = cyc; mode = 2'b01;
    adv(2);
    for (int i = 0; i < 20; i++) begin
      chk("div0_cpu_en", cpu_en, 1);
      adv(1);
    end
    for (int k = e + 2; k <= e + 22; k++) exp_q.push_back(k);
    mode = 2'b00;
    adv(2);
    check_pulses("div0_run");

    // asynchronous clear in the middle of RUN
    load_div(3);
    mode = 2'b01;
    adv(12);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_cpu_en", cpu_en, 0);
    chk("clr_clkout", clkout, 0);
    chk("clr_busy", busy, 0);
    chk("clr_tick_cnt", tick_cnt, 0);
    mode = 2'b00;
    adv(2);
    pulses.delete();
    exp_ticks = 0;
    clr = 1'b0;
    adv(1);

    // 0x10000 steps wrap tick_cnt back to 0
    load_div(0);
    e = cyc; mode = 2'b01;
    adv(65536);
    chk("wrap_ffff", tick_cnt, 16'hFFFF);
    adv(1);
    chk("wrap_zero", tick_cnt, 0);
    chk("wrap_clkout", clkout, 0);
    mode = 2'b00;
    adv(2);
    $display("wrap: %0d pulses seen after clear", pulses.size());
    pulses.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Clock-enable controller for the lab microprocessor. It decides when the CPU advances one instruction step. It supports halt, free-run at a programmable rate, single-step from a push button, and fixed-length bursts. It owns the step-rate divider and the button debouncer, drives a single-cycle `cpu_en` strobe into the CPU datapath, and drives a toggling `clkout` for display and LED logic.

## Interface
- `CNT_W`, default 32: divider counter and divisor width.
- `DEF_DIV`, default 25000000: divisor loaded at reset (2 Hz step rate at 50 MHz).
- `DB_CYCLES`, default 1000000: debounce stability window, in clkin cycles.
- `clkin`, in, 1: system clock. All logic is on the rising edge.
- `clr`, in, 1: reset, asynchronous, active-high.
- `mode`, in, 2: operating mode, synchronous, sampled every cycle. 00 HALT, 01 RUN, 10 STEP, 11 BURST.
- `step_btn`, in, 1: raw asynchronous push button, active-high.
- `div_load`, in, 1: one-cycle strobe that loads `div_val` into the divisor.
- `div_val`, in, CNT_W: new divisor. A value of 0 is stored as 1.
- `burst_len`, in, 8: number of steps per burst. A value of 0 means 256.
- `cpu_en`, out, 1: registered step strobe, one cycle per CPU step.
- `clkout`, out, 1: toggles on every `cpu_en`.
- `busy`, out, 1: high while a burst is in progress.
- `tick_cnt`, out, 16: total steps issued. Wraps from 0xFFFF to 0.

## Operation
- **Reset values:** `cpu_en`=0, `clkout`=0, `busy`=0, `tick_cnt`=0. Internally: divisor=DEF_DIV, divider count=0, burst remaining=0, debounced level=0, synchronizers=0.
- **Button path:**
  - 2-flop synchronizer on `step_btn`, output s2.
  - While s2 differs from the debounced level, the debounce counter increments.
  - When the counter reaches DB_CYCLES-1 with s2 still differing, the debounced level takes s2 and the counter clears.
  - When s2 equals the debounced level, the counter clears.
  - A 0→1 change of the debounced level raises a one-cycle `press` event.
- **Divider:**
  - Counts 0 to divisor-1 only in RUN, or in BURST while `busy` is high.
  - A tick occurs when count ≥ divisor-1; the count then returns to 0.
  - In all other conditions the count is held at 0.
  - The count is cleared on any mode change, so the first step comes a full divisor after entry.
- **Mode behaviour:**
  - HALT: no steps. An active burst is aborted: `busy`→0, remaining→0.
  - RUN: one `cpu_en` per tick, so the step period is divisor cycles. With divisor=1, `cpu_en` stays high continuously.
  - STEP: each `press` produces exactly one `cpu_en`. The divider is unused.
  - BURST: a `press` while `busy`=0 latches the effective burst length (1..256) as remaining and sets `busy`.
    - Each tick issues `cpu_en` and decrements remaining.
    - The tick that brings remaining to 0 also clears `busy` on the same edge.
    - A `press` while `busy`=1 is ignored.
- A `press` in HALT or RUN is ignored. The debouncer keeps tracking the button in every mode.
- Leaving BURST mid-burst aborts the burst. Returning to BURST requires a new `press`.
- **Divisor load:**
  - `div_load` takes effect on the next edge, in any mode.
  - If the current count is already ≥ new divisor-1, the next cycle ticks and the count wraps to 0. There is no long wrap through 2^CNT_W.
  - If `div_load` and a tick fall in the same cycle, the tick uses the old divisor and later ticks use the new one.
- **On every `cpu_en`:** `clkout` toggles and `tick_cnt` increments, both registered on the same edge as `cpu_en`.

## Timing
- `cpu_en` is registered: it goes high on the edge after the tick or `press` condition and lasts exactly one cycle (except the divisor=1 case in RUN).
- **Button latency:** `step_btn` rises and stays stable.
  - s2 is high after 2 edges.
  - The debounced level is high after DB_CYCLES more edges.
  - `press` is registered on the next edge.
  - `cpu_en` follows on the edge after that: DB_CYCLES+4 edges total.
- Glitches shorter than DB_CYCLES cycles produce no `press`.
- **RUN entry:** `mode` becomes 01 at edge 0. `cpu_en` is high in the cycles after edges divisor+1, 2·divisor+1, and so on.
- **Async `clr` mid-operation:** returns every output to its reset value immediately. Mode is re-evaluated on the first edge after release.
- `mode` changes take effect on the next edge. No pending step survives a mode change.

## Test plan
- Reset, then `mode`=01 with DEF_DIV overridden to 4 → `cpu_en` pulses every 4 cycles; after 10 pulses `tick_cnt`=10 and `clkout`=0.
- DB_CYCLES=4, `mode`=10. A 3-cycle glitch on `step_btn` → no `cpu_en`. A clean press held 20 cycles → exactly one `cpu_en`, DB_CYCLES+4=8 edges after the rise.
- DB_CYCLES=4, `mode`=11, divisor=2, `burst_len`=3, one press → 3 `cpu_en` pulses 2 cycles apart; `busy` falls with the third pulse; a second press during the burst adds nothing.
- `burst_len`=0 → 256 pulses, then `busy`=0. Switch `mode` to 00 mid-burst → pulses stop and `busy`=0 on the next edge.
- RUN with divisor=10 and count at 7, `div_load` with `div_val`=3 → tick on the next cycle, then a period of 3. `div_val`=0 → `cpu_en` held high continuously.
- Assert `clr` in the middle of RUN → all outputs read 0 immediately. Run 0x10000 steps → `tick_cnt` wraps to 0.
